// File: rtl/rfwb_pkg.sv
// Shared types and constants for the register-file write-back path.
// Used by the write-back queue and by the register-file decoder/mux.
package rfwb_pkg;

  localparam int AW       = 4;
  localparam int DW       = 32;
  localparam int NUM_REGS = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rfwb_bypass_match.sv
// Youngest-match search over the in-flight write-back entries.
// Built only when RFWB_BYPASS_EN is defined.
module rfwb_bypass_match
  import rfwb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = rfwb_pkg::AW,
  parameter int DW    = rfwb_pkg::DW,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = PW + 1
) (
  input  logic [AW-1:0] addr_q [DEPTH],
  input  logic [DW-1:0] data_q [DEPTH],
  input  logic [PW-1:0] head,
  input  logic [CW-1:0] count,
  input  logic [AW-1:0] rd_addr,
  output logic          hit,
  output logic [DW-1:0] data
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count && addr_q[idx] == rd_addr) begin
        hit  = 1'b1;
        data = data_q[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue feeding the 16x32 register file write port.
// Define RFWB_BYPASS_EN to enable the in-flight bypass lookup.
module regfile_wb_queue
  import rfwb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = rfwb_pkg::AW,
  parameter int DW    = rfwb_pkg::DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  output logic                     in_ready,
  input  logic                     rf_stall,
  output logic                     wr_en,
  output logic [AW-1:0]            wr_addr,
  output logic [DW-1:0]            wr_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop_err,
  input  logic [AW-1:0]            rd_addr,
  output logic                     byp_hit,
  output logic [DW-1:0]            byp_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          push;
  logic          pop;

  assign in_ready = count < CW'(DEPTH);
  assign wr_en    = count != '0;
  assign push     = in_valid & in_ready;
  assign pop      = wr_en & ~rf_stall;
  assign wr_addr  = wr_en ? addr_q[head] : '0;
  assign wr_data  = wr_en ? data_q[head] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      drop_err <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (in_valid && !in_ready) drop_err <= 1'b1;
    end
  end

  // Storage is deliberately left unreset; only occupancy decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= in_addr;
      data_q[tail] <= in_data;
    end
  end

`ifdef RFWB_BYPASS_EN
  rfwb_bypass_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_byp (
    .addr_q  (addr_q),
    .data_q  (data_q),
    .head    (head),
    .count   (count),
    .rd_addr (rd_addr),
    .hit     (byp_hit),
    .data    (byp_data)
  );
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign byp_hit        = 1'b0;
  assign byp_data       = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed self-checking bench for regfile_wb_queue.
// Bypass checks follow RFWB_BYPASS_EN.
module tb_regfile_wb_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_addr;
  logic [31:0] in_data;
  logic        in_ready;
  logic        rf_stall;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  count;
  logic        drop_err;
  logic [3:0]  rd_addr;
  logic        byp_hit;
  logic [31:0] byp_data;

  int vectors = 0;
  int miscompares = 0;

  regfile_wb_queue #(.DEPTH(4), .AW(4), .DW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .in_ready (in_ready),
    .rf_stall (rf_stall),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .count    (count),
    .drop_err (drop_err),
    .rd_addr  (rd_addr),
    .byp_hit  (byp_hit),
    .byp_data (byp_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [31:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
    rf_stall = 1'b0; rd_addr = '0;
    @(negedge clk);
    step();
    rst = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_drop", 32'(drop_err), 0);
    chk("rst_waddr", 32'(wr_addr), 0);
    chk("rst_wdata", wr_data, 0);

    // single push then drain
    push(4'd3, 32'hAABBAABB);
    chk("t1_wr_en", 32'(wr_en), 1);
    chk("t1_addr", 32'(wr_addr), 3);
    chk("t1_data", wr_data, 32'hAABBAABB);
    chk("t1_count1", 32'(count), 1);
    step();
    chk("t1_count0", 32'(count), 0);
    chk("t1_wr_en0", 32'(wr_en), 0);

    // fill under stall, overflow, then drain in order
    rf_stall = 1'b1;
    for (int i = 0; i < 4; i++) push(4'(i), 32'h100 + 32'(i));
    chk("t2_count", 32'(count), 4);
    chk("t2_ready", 32'(in_ready), 0);
    chk("t2_drop0", 32'(drop_err), 0);
    chk("t2_hold", 32'(wr_addr), 0);
    push(4'd9, 32'hDEAD);
    chk("t2_drop1", 32'(drop_err), 1);
    chk("t2_count_ovf", 32'(count), 4);
    chk("t2_stall_en", 32'(wr_en), 1);
    rf_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain_addr", 32'(wr_addr), 32'(i));
      chk("t2_drain_data", wr_data, 32'h100 + 32'(i));
      step();
    end
    chk("t2_empty", 32'(count), 0);
    chk("t2_drop_held", 32'(drop_err), 1);

    // steady push+pop at count 2
    rf_stall = 1'b1;
    push(4'd0, 32'hC000);
    push(4'd1, 32'hC001);
    rf_stall = 1'b0;
    chk("t3_count_pre", 32'(count), 2);
    for (int j = 2; j < 12; j++) begin
      chk("t3_head_addr", 32'(wr_addr), 32'(j - 2));
      chk("t3_head_data", wr_data, 32'hC000 + 32'(j - 2));
      push(4'(j), 32'hC000 + 32'(j));
      chk("t3_count", 32'(count), 2);
    end
    chk("t3_tail_addr0", 32'(wr_addr), 10);
    step();
    chk("t3_tail_addr1", 32'(wr_addr), 11);
    chk("t3_tail_data1", wr_data, 32'hC00B);
    step();
    chk("t3_empty", 32'(count), 0);

    // bypass lookup
    rf_stall = 1'b1;
    push(4'd5, 32'h1);
    push(4'd5, 32'h2);
    push(4'd7, 32'h3);
`ifdef RFWB_BYPASS_EN
    rd_addr = 4'd5; #1;
    chk("t5_hit5", 32'(byp_hit), 1);
    chk("t5_data5", byp_data, 32'h2);
    rd_addr = 4'd6; #1;
    chk("t5_hit6", 32'(byp_hit), 0);
    chk("t5_data6", byp_data, 0);
    rd_addr = 4'd7; #1;
    chk("t5_hit7", 32'(byp_hit), 1);
    chk("t5_data7", byp_data, 32'h3);
`else
    rd_addr = 4'd5; #1;
    chk("t5_hit_off", 32'(byp_hit), 0);
    chk("t5_data_off", byp_data, 0);
`endif
    rd_addr = 4'd0;

    // reset mid-drain with drop_err set
    chk("t4_count3", 32'(count), 3);
    rf_stall = 1'b0;
    step();
    chk("t4_count2", 32'(count), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_wr_en", 32'(wr_en), 0);
    chk("t4_count", 32'(count), 0);
    chk("t4_drop", 32'(drop_err), 0);
    chk("t4_ready", 32'(in_ready), 1);
    chk("t4_waddr", 32'(wr_addr), 0);
    chk("t4_wdata", wr_data, 0);

    // empty queue, stall toggling
    for (int k = 0; k < 4; k++) begin
      rf_stall = k[0];
      step();
      chk("t6_wr_en", 32'(wr_en), 0);
      chk("t6_waddr", 32'(wr_addr), 0);
      chk("t6_wdata", wr_data, 0);
    end

    // address 0 is ordinary after reset, head restarted at 0
    push(4'd0, 32'h5A5A0000);
    chk("t7_addr0", 32'(wr_addr), 0);
    chk("t7_data0", wr_data, 32'h5A5A0000);
    chk("t7_en", 32'(wr_en), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
